tt_um_histogram: RTL and testbench

TT_UM_HISTOGRAM -- requirements
Module: tt_um_histogram

---
 rtl/histo_pkg.sv | 23 ++
 rtl/histo_bank.sv | 67 ++++++
 rtl/tt_um_histogram.sv | 105 ++++++++++
 tb/tb_tt_um_histogram.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/histo_pkg.sv
// Shared definitions for the histogram block: FSM state encoding and uio pin positions.
// Imported by the top and the bin bank so both agree on pin mapping.
package histo_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // uio_in bit positions
   localparam int UIO_SMP_VLD = 0;
   localparam int UIO_CLR     = 1;
   localparam int UIO_RD_REQ  = 2;
   localparam int UIO_RIDX_LO = 3;
   localparam int UIO_RIDX_HI = 5;

   // uio_out bit positions
   localparam int UIO_OVF     = 6;
   localparam int UIO_BUSY    = 7;

   localparam logic [7:0] UIO_OE_VAL = 8'b1100_0000;

endpackage

// File: rtl/histo_bank.sv
// Bin storage with saturating increment, sticky overflow and a one-bin-per-cycle clear sweep.
// Updates land on the clock edge that samples inc_i/sweep_i; reads are combinational from stored bins.
module histo_bank
   import histo_pkg::*;
#(
   parameter  int NUM_BINS = 8,
   parameter  int CNT_W    = 8,
   localparam int BIN_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic [BIN_W-1:0] inc_idx_i,
   input  logic             sweep_i,
   input  logic [2:0]       rd_idx_i,
   output logic             sweep_last_o,
   output logic [CNT_W-1:0] rd_val_o,
   output logic             ovf_o
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(NUM_BINS - 1);

   logic [CNT_W-1:0] bin_q [NUM_BINS];
   logic [CNT_W-1:0] bin_d [NUM_BINS];
   logic [BIN_W-1:0] sweep_q, sweep_d;
   logic             ovf_q, ovf_d;

   assign sweep_last_o = (sweep_q == LAST_IDX);
   assign ovf_o        = ovf_q;
   assign rd_val_o     = (int'(rd_idx_i) < NUM_BINS) ? bin_q[rd_idx_i[BIN_W-1:0]] : '0;

   always_comb begin
      bin_d   = bin_q;
      sweep_d = sweep_q;
      ovf_d   = ovf_q;
      if (sweep_i) begin
         // Sweep pointer wraps to 0 after the last bin, ready for the next clear.
         bin_d[sweep_q] = '0;
         sweep_d        = sweep_q + 1'b1;
         if (sweep_last_o) begin
            ovf_d = 1'b0;
         end
      end else if (inc_i) begin
         if (bin_q[inc_idx_i] == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            bin_d[inc_idx_i] = bin_q[inc_idx_i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BINS; i++) begin
            bin_q[i] <= '0;
         end
         sweep_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         bin_q   <= bin_d;
         sweep_q <= sweep_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: rtl/tt_um_histogram.sv
// Histogram top: sample edge detect, IDLE/CLEAR control and pin mapping around histo_bank.
// Bin updates one cycle after a sample edge; uo_out loads the requested bin one cycle after read_req.
module tt_um_histogram
   import histo_pkg::*;
#(
   parameter int NUM_BINS = 8,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

   state_e           state_q, state_d;
   logic             smp_q;
   logic             smp_edge;
   logic             inc;
   logic             sweep;
   logic             sweep_last;
   logic             ovf;
   logic [CNT_W-1:0] rd_val;
   logic [7:0]       rd_val8;
   logic [7:0]       uo_q, uo_d;
   logic             unused_ok;

   assign smp_edge = uio_in[UIO_SMP_VLD] & ~smp_q;

   // A clear in IDLE wins over a coincident sample edge, which is dropped.
   always_comb begin
      state_d = state_q;
      inc     = 1'b0;
      sweep   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (uio_in[UIO_CLR]) begin
               state_d = ST_CLEAR;
            end else begin
               inc = smp_edge;
            end
         end
         ST_CLEAR: begin
            sweep = 1'b1;
            if (sweep_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign uo_d = uio_in[UIO_RD_REQ] ? rd_val8 : uo_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         smp_q   <= 1'b0;
         uo_q    <= '0;
      end else begin
         state_q <= state_d;
         smp_q   <= uio_in[UIO_SMP_VLD];
         uo_q    <= uo_d;
      end
   end

   histo_bank #(
      .NUM_BINS (NUM_BINS),
      .CNT_W    (CNT_W)
   ) u_bank (
      .clk          (clk),
      .rst_n        (rst_n),
      .inc_i        (inc),
      .inc_idx_i    (ui_in[7 -: BIN_W]),
      .sweep_i      (sweep),
      .rd_idx_i     (uio_in[UIO_RIDX_HI:UIO_RIDX_LO]),
      .sweep_last_o (sweep_last),
      .rd_val_o     (rd_val),
      .ovf_o        (ovf)
   );

   generate
      if (CNT_W >= 8) begin : g_trunc
         assign rd_val8 = rd_val[7:0];
      end else begin : g_ext
         assign rd_val8 = {{(8 - CNT_W){1'b0}}, rd_val};
      end
   endgenerate

   always_comb begin
      uio_out           = '0;
      uio_out[UIO_BUSY] = (state_q == ST_CLEAR);
      uio_out[UIO_OVF]  = ovf;
   end

   assign uo_out    = uo_q;
   assign uio_oe    = UIO_OE_VAL;
   assign unused_ok = &{1'b0, ena, ui_in, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_histogram.sv
// Scoreboard bench for tt_um_histogram: stimulus queues expectations, a negedge monitor pops and compares.
module tb_tt_um_histogram;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   always #5 clk = ~clk;

   tt_um_histogram #(
      .NUM_BINS (8),
      .CNT_W    (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   typedef struct {
      string name;
      int    sel;   // 0: uo_out, 1: uio_out, 2: uio_oe
      int    exp;
   } chk_t;

   chk_t st_q[$];
   chk_t rd_q[$];
   int   busy_q[$];
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   busy_run = 0;
   logic rd_cap   = 1'b0;

   function automatic void check(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endfunction

   function automatic void fail_now(string name);
      n_chk++;
      $display("FAIL %s: got no matching DUT event, expected one", name);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pin(string name, int sel, int exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      st_q.push_back(c);
   endtask

   task automatic push_read(string name, int idx, int exp);
      chk_t c;
      c.name = name;
      c.sel  = 0;
      c.exp  = exp;
      uio_in[5:3] = 3'(idx);
      uio_in[2]   = 1'b1;
      rd_q.push_back(c);
   endtask

   task automatic read_bin(string name, int idx, int exp);
      push_read(name, idx, exp);
      tick();
      uio_in[2] = 1'b0;
   endtask

   task automatic sample(logic [7:0] v);
      ui_in     = v;
      uio_in[0] = 1'b1;
      tick();
      uio_in[0] = 1'b0;
      tick();
   endtask

   // Monitor: a read sampled at a posedge is visible on uo_out by the following negedge.
   always @(posedge clk) rd_cap <= uio_in[2] & rst_n;

   always @(negedge clk) begin
      chk_t c;
      while (st_q.size() > 0) begin
         c = st_q.pop_front();
         case (c.sel)
            0:       check(c.name, int'(uo_out), c.exp);
            1:       check(c.name, int'(uio_out), c.exp);
            default: check(c.name, int'(uio_oe), c.exp);
         endcase
      end
      if (rd_cap) begin
         if (rd_q.size() == 0) fail_now("unexpected_read");
         else begin
            c = rd_q.pop_front();
            check(c.name, int'(uo_out), c.exp);
         end
      end
      if (uio_out[7] === 1'b1) busy_run++;
      else if (busy_run != 0) begin
         if (busy_q.size() == 0) fail_now("unexpected_busy");
         else check("busy_len", busy_run, busy_q.pop_front());
         busy_run = 0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      tick();
      tick();
      expect_pin("rst_uo", 0, 0);
      expect_pin("rst_uio", 1, 0);
      expect_pin("uio_oe", 2, 8'hC0);
      tick();
      rst_n = 1'b1;
      tick();

      // Basic binning on separate edges
      sample(8'h00);
      sample(8'h20);
      sample(8'hE5);
      read_bin("bin0_basic", 0, 1);
      read_bin("bin1_basic", 1, 1);
      read_bin("bin7_basic", 7, 1);
      read_bin("bin2_empty", 2, 0);
      expect_pin("uio_oe_run", 2, 8'hC0);

      // Held-high sample_valid counts once
      ui_in     = 8'h40;
      uio_in[0] = 1'b1;
      repeat (10) tick();
      uio_in[0] = 1'b0;
      tick();
      read_bin("bin2_held", 2, 1);

      // Saturation and sticky overflow
      for (int i = 0; i < 255; i++) sample(8'h60);
      expect_pin("ovf_at_255", 1, 8'h00);
      read_bin("bin3_255", 3, 255);
      for (int i = 0; i < 45; i++) sample(8'h60);
      expect_pin("ovf_set", 1, 8'h40);
      read_bin("bin3_sat", 3, 255);
      read_bin("bin0_keep", 0, 1);
      read_bin("bin4_zero", 4, 0);

      // Clear sweep with ignored edges, a re-clear and reads mid-sweep
      busy_q.push_back(8);
      uio_in[1] = 1'b1;
      tick();
      uio_in[1] = 1'b0;
      ui_in     = 8'h00;
      uio_in[0] = 1'b1;
      push_read("bin7_mid_sweep", 7, 1);
      tick();
      uio_in[0] = 1'b0;
      push_read("bin0_swept", 0, 0);
      tick();
      uio_in[2] = 1'b0;
      uio_in[1] = 1'b1;
      uio_in[0] = 1'b1;
      tick();
      uio_in[1] = 1'b0;
      uio_in[0] = 1'b0;
      tick();
      uio_in[0] = 1'b1;
      tick();
      uio_in[0] = 1'b0;
      tick();
      tick();
      expect_pin("ovf_last_sweep", 1, 8'hC0);
      tick();
      expect_pin("after_sweep", 1, 8'h00);
      for (int i = 0; i < 8; i++) read_bin($sformatf("cleared_bin%0d", i), i, 0);

      // Clear and sample edge together: sample dropped
      busy_q.push_back(8);
      ui_in     = 8'h20;
      uio_in[1] = 1'b1;
      uio_in[0] = 1'b1;
      tick();
      uio_in[1] = 1'b0;
      uio_in[0] = 1'b0;
      repeat (10) tick();
      read_bin("clr_drops_sample", 1, 0);

      // Read of a bin during its increment returns the old value
      sample(8'h80);
      sample(8'h80);
      ui_in     = 8'h80;
      uio_in[0] = 1'b1;
      push_read("rd_same_bin_old", 4, 2);
      tick();
      uio_in[0] = 1'b0;
      push_read("rd_same_bin_new", 4, 3);
      tick();
      uio_in[2] = 1'b0;

      // Reset in the middle of a sweep
      busy_q.push_back(3);
      uio_in[1] = 1'b1;
      tick();
      uio_in[1] = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      expect_pin("rst_mid_uio", 1, 8'h00);
      expect_pin("rst_mid_uo", 0, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      expect_pin("post_rst_uio", 1, 8'h00);
      for (int i = 0; i < 8; i++) read_bin($sformatf("post_rst_bin%0d", i), i, 0);
      sample(8'hA0);
      read_bin("post_rst_count", 5, 1);
      read_bin("post_rst_bin4", 4, 0);

      repeat (4) tick();
      while (rd_q.size() > 0) fail_now(rd_q.pop_front().name);
      while (st_q.size() > 0) fail_now(st_q.pop_front().name);
      while (busy_q.size() > 0) begin
         void'(busy_q.pop_front());
         fail_now("busy_len_pending");
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
